// File: rtl/inv_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// inv_key_sched_ctrl
// Iterative AES-128 decryption key-schedule controller. Takes the round-10
// key and walks the expansion backwards one step per handshake, streaming
// round keys 10..0 to the inverse-cipher datapath.
//
// Optional feature macro: KEY_CACHE_EN (adds an 11-entry round-key cache)
//
// Ports:
//   clk         : clock, all state changes on rising edge
//   rst_n       : synchronous active-low reset
//   start       : one-cycle request, sampled only while idle
//   last_key    : round-10 key, w0 = [0:31] ... w3 = [96:127]
//   rk_valid    : rk_data holds a valid round key
//   rk_ready    : consumer accepts the current key
//   rk_data     : current round key
//   rk_round    : index of rk_data (10 down to 0)
//   busy        : sequence in progress (through the done cycle)
//   done        : one-cycle pulse after round 0 is accepted
//   rd_round    : cache read index (cache build only)
//   rd_key      : registered cache read data (cache build only, else 0)
//   cache_valid : all 11 keys held in cache (cache build only, else 0)
// ---------------------------------------------------------------------------
module inv_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] last_key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk_data,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [0:127] rd_key,
  output logic         cache_valid
);

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  // Forward AES S-box, byte i lives at bits [8*i +: 8]
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{a, 3'b000} +: 8];
  endfunction

  state_t       state;
  logic [0:127] key_reg;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [0:31]  w0n, w1n, w2n, w3n, rot;
  logic [0:127] prev_key;
  logic         handshake;

  assign rk_data   = key_reg;
  assign rk_round  = round;
  assign handshake = rk_valid && rk_ready;

  // Rcon is selected by the round currently held, i.e. the one being undone
  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Inverse expansion step: the new w3 must be formed before it feeds w0
  always_comb begin
    w3n = key_reg[96:127] ^ key_reg[64:95];
    w2n = key_reg[64:95]  ^ key_reg[32:63];
    w1n = key_reg[32:63]  ^ key_reg[0:31];
    rot = {w3n[8:31], w3n[0:7]};
    w0n = key_reg[0:31] ^ {sbox(rot[0:7]), sbox(rot[8:15]),
                           sbox(rot[16:23]), sbox(rot[24:31])}
                        ^ {rcon, 24'h000000};
    prev_key = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_reg  <= '0;
      round    <= 4'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            key_reg  <= last_key;
            round    <= 4'd10;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (round != 4'd0) begin
              key_reg <= prev_key;
              round   <= round - 4'd1;
            end else begin
              // Round 0 is terminal: key and round stay put, no wrap
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_CACHE_EN
  logic [0:127] cache [0:10];

  // Every accepted key is filed under its round; the round-0 write lands on
  // the same edge that raises cache_valid, so the cache is full when it rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) cache[i] <= '0;
      rd_key      <= '0;
      cache_valid <= 1'b0;
    end else begin
      if (handshake) cache[round] <= key_reg;
      if (handshake && round == 4'd0) cache_valid <= 1'b1;
      else if (state == IDLE && start) cache_valid <= 1'b0;
      if (rd_round <= 4'd10) rd_key <= cache[rd_round];
      else rd_key <= '0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd   = ^{rd_round, handshake};
  assign rd_key      = '0;
  assign cache_valid = 1'b0;
`endif

endmodule

// File: tb/tb_inv_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inv_key_sched_ctrl
// Self-checking bench for inv_key_sched_ctrl. Expected round keys come from a
// reference model that builds the S-box from GF(2^8) arithmetic and unwinds
// the 44-word AES-128 expansion array from its last four words.
// ---------------------------------------------------------------------------
module tb_inv_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [0:127] last_key;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] rk_data;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
  logic [3:0]   rd_round;
  logic [0:127] rd_key;
  logic         cache_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sboxTab [0:255];
  logic [7:0]   rconTab [1:10];
  logic [0:127] expKeys [0:10];
  logic [0:127] seenKeys [0:10];

  localparam logic [0:127] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [0:127] FIPS_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  // With every word zero only w0 picks up SubWord(0)=63636363 and Rcon 36
  localparam logic [0:127] ZERO_R9  = 128'h55636363000000000000000000000000;

  inv_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .busy(busy), .done(done), .rd_round(rd_round),
    .rd_key(rd_key), .cache_valid(cache_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [159:0] got,
                             input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse; Rcon = powers of 2
  task automatic buildTables();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sboxTab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
    end
    rconTab[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rconTab[i] = gmul(rconTab[i-1], 8'h02);
  endtask

  function automatic logic [31:0] subRot(input logic [31:0] t);
    logic [31:0] r = {t[23:0], t[31:24]};
    return {sboxTab[r[31:24]], sboxTab[r[23:16]], sboxTab[r[15:8]], sboxTab[r[7:0]]};
  endfunction

  // Forward rule w[i] = w[i-4] ^ f(w[i-1]) solved for w[i-4], from the top down
  task automatic buildModel(input logic [0:127] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    w[40] = key[0:31];  w[41] = key[32:63];
    w[42] = key[64:95]; w[43] = key[96:127];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = subRot(t) ^ {rconTab[i/4], 24'h000000};
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      expKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full (or reset-aborted) key sequence; inputs change at negedges
  task automatic applyStimulus(input logic [0:127] key, input int readyPct,
                               input bit pokeStart, input int abortRound,
                               input bit checkLatency);
    int  expRound = 10;
    int  cycles   = 0;
    bit  finished = 0;
    bit  aborted  = 0;
    bit  hs;
    buildModel(key);
    start = 1'b1; last_key = key; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
`ifdef KEY_CACHE_EN
    checkOutput("cache_valid_drop", 160'(cache_valid), 160'(1'b0));
`endif
    while (!finished && cycles < 200) begin
      if (abortRound == expRound) begin
        rst_n = 1'b0; rk_ready = 1'b0;
        @(negedge clk);
        checkOutput("abort_reset", {rk_valid, busy, done, rk_round, rk_data},
                    160'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("abort_no_done", {rk_valid, busy, done}, 160'(0));
        end
        aborted = 1; finished = 1;
      end else begin
        checkOutput("emit", {rk_valid, busy, done, rk_round, rk_data},
                    {1'b1, 1'b1, 1'b0, 4'(expRound), expKeys[expRound]});
        if (pokeStart && expRound == 7) begin
          start = 1'b1; last_key = ~key;
        end else begin
          start = 1'b0;
        end
        rk_ready = ($urandom_range(99) < readyPct);
        hs = rk_ready;
        if (hs) seenKeys[expRound] = rk_data;
        @(negedge clk);
        cycles++;
        if (hs) begin
          if (expRound == 0) finished = 1;
          else expRound--;
        end
      end
    end
    start = 1'b0;
    if (!finished) begin
      checkOutput("timeout", 160'(0), 160'(1));
    end else if (!aborted) begin
      checkOutput("done_pulse", {rk_valid, busy, done}, 160'(3'b011));
      if (checkLatency) checkOutput("done_latency", 160'(cycles), 160'(11));
      rk_ready = 1'b0;
      @(negedge clk);
      checkOutput("idle_after", {rk_valid, busy, done}, 160'(0));
`ifdef KEY_CACHE_EN
      checkOutput("cache_valid_set", 160'(cache_valid), 160'(1'b1));
`endif
    end
  endtask

  // Registered cache reads, or the tie-offs in the plain build
  task automatic checkCache();
    logic [3:0] r;
    for (int i = 0; i < 8; i++) begin
      r = (i == 0) ? 4'd9 : (i == 1) ? 4'd12 : 4'($urandom_range(15));
      rd_round = r;
      @(negedge clk);
`ifdef KEY_CACHE_EN
      checkOutput("cache_rd", 160'(rd_key), (r <= 4'd10) ? 160'(expKeys[r]) : 160'(0));
`else
      checkOutput("cache_tied", {cache_valid, rd_key}, 160'(0));
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; last_key = '0; rk_ready = 1'b0; rd_round = '0;
    buildTables();
    repeat (2) @(negedge clk);
    checkOutput("reset_state",
                {rk_valid, busy, done, rk_round, rk_data, cache_valid}, 160'(0));
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(FIPS_R10, 100, 0, -1, 1);
    checkOutput("fips_r10", 160'(seenKeys[10]), 160'(FIPS_R10));
    checkOutput("fips_r9",  160'(seenKeys[9]),  160'(FIPS_R9));
    checkOutput("fips_r0",  160'(seenKeys[0]),  160'(FIPS_R0));
    checkCache();

    applyStimulus(FIPS_R10, 50, 1, -1, 0);
    checkOutput("stall_r0", 160'(seenKeys[0]), 160'(FIPS_R0));

    applyStimulus(FIPS_R10, 70, 0, 5, 0);
    applyStimulus(FIPS_R10, 100, 0, -1, 1);

    applyStimulus('0, 80, 0, -1, 0);
    checkOutput("zero_r9", 160'(seenKeys[9]), 160'(ZERO_R9));

    for (int n = 0; n < 4; n++) begin
      applyStimulus({$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(30, 100), n[0], -1, 0);
      checkCache();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
